// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider: per-channel divided clock, tick strobe and
// glitch-free divisor reload. Define CLKDIV_READBACK_EN to add the div_cur readback output.
module clock_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 28
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH*CNT_W-1:0]   div_in,
    input  logic [NUM_CH-1:0]         div_load,
    input  logic                      align,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         pend
`ifdef CLKDIV_READBACK_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]   div_cur
`endif
);

    localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_D = CNT_W'(2);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_d;
            logic [CNT_W-1:0] r_p;
            logic [CNT_W-1:0] r_c;
            logic             r_pf;
            logic             r_clk;
            logic             r_tick;

            logic [CNT_W-1:0] w_div_raw;
            logic [CNT_W-1:0] w_ld_val;
            logic [CNT_W-1:0] w_half;
            logic [CNT_W-1:0] w_low;
            logic             w_wrap;
            logic [CNT_W-1:0] w_c_next;

            assign w_div_raw = div_in[gi*CNT_W +: CNT_W];
            assign w_ld_val  = (w_div_raw < MIN_D) ? MIN_D : w_div_raw;
            // Odd divisors give the spare cycle to the low phase.
            assign w_half    = r_d >> 1;
            assign w_low     = r_d - w_half;
            assign w_wrap    = (r_c == (r_d - 1'b1));
            assign w_c_next  = w_wrap ? '0 : (r_c + 1'b1);

            always_ff @(posedge clk_in) begin
                if (rst) begin
                    r_d    <= DEF_D;
                    r_p    <= DEF_D;
                    r_pf   <= 1'b0;
                    r_c    <= '0;
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                end else if (align) begin
                    r_c    <= '0;
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                    if (div_load[gi]) begin
                        r_d  <= w_ld_val;
                        r_p  <= w_ld_val;
                        r_pf <= 1'b0;
                    end else if (r_pf) begin
                        r_d  <= r_p;
                        r_pf <= 1'b0;
                    end
                end else begin
                    if (en[gi]) begin
                        r_c    <= w_c_next;
                        r_clk  <= (w_c_next >= w_low);
                        r_tick <= (w_c_next == '0);
                    end else begin
                        r_tick <= 1'b0;
                    end
                    // New divisors only take effect at a wrap, so no runt period is produced.
                    if (div_load[gi]) begin
                        r_p <= w_ld_val;
                        if (en[gi] && w_wrap) begin
                            r_d  <= w_ld_val;
                            r_pf <= 1'b0;
                        end else begin
                            r_pf <= 1'b1;
                        end
                    end else if (en[gi] && w_wrap && r_pf) begin
                        r_d  <= r_p;
                        r_pf <= 1'b0;
                    end
                end
            end

            assign clk_out[gi] = r_clk;
            assign tick[gi]    = r_tick;
            assign pend[gi]    = r_pf;
`ifdef CLKDIV_READBACK_EN
            assign div_cur[gi*CNT_W +: CNT_W] = r_d;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_clock_div_multi.sv
// Randomised and directed bench for clock_div_multi, checked every cycle against a
// period-position model of each channel.
module tb_clock_div_multi;
    localparam int N = 4;
    localparam int W = 16;

    logic             clk_in = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     en = '0;
    logic [N*W-1:0]   div_in = '0;
    logic [N-1:0]     div_load = '0;
    logic             align = 1'b0;
    logic [N-1:0]     clk_out;
    logic [N-1:0]     tick;
    logic [N-1:0]     pend;
`ifdef CLKDIV_READBACK_EN
    logic [N*W-1:0]   div_cur;
`endif

    always #5 clk_in = ~clk_in;

    clock_div_multi #(.NUM_CH(N), .CNT_W(W), .DEFAULT_DIV(28)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .align    (align),
        .clk_out  (clk_out),
        .tick     (tick),
`ifdef CLKDIV_READBACK_EN
        .pend     (pend),
        .div_cur  (div_cur)
`else
        .pend     (pend)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: active divisor, pending divisor, and how many enabled edges into the period we are.
    int m_d[N];
    int m_p[N];
    int m_pos[N];
    bit m_pf[N];
    bit m_clk[N];
    bit m_tick[N];
    bit live = 1'b0;

    function automatic int clampv(int v);
        return (v < 2) ? 2 : v;
    endfunction

    always @(posedge clk_in) begin
        for (int i = 0; i < N; i++) begin
            int ld;
            bit at_end;
            ld = clampv(int'(div_in[i*W +: W]));
            if (rst) begin
                m_d[i] = 28; m_p[i] = 28; m_pf[i] = 0; m_pos[i] = 0;
                m_clk[i] = 0; m_tick[i] = 0;
            end else if (align) begin
                m_pos[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
                if (div_load[i]) begin
                    m_d[i] = ld; m_p[i] = ld; m_pf[i] = 0;
                end else if (m_pf[i]) begin
                    m_d[i] = m_p[i]; m_pf[i] = 0;
                end
            end else begin
                at_end = en[i] && (m_pos[i] + 1 == m_d[i]);
                if (en[i]) begin
                    m_pos[i]  = (m_pos[i] + 1) % m_d[i];
                    // High for the last floor(D/2) positions of the period.
                    m_clk[i]  = (m_pos[i] >= (m_d[i] + 1) / 2);
                    m_tick[i] = (m_pos[i] == 0);
                end else begin
                    m_tick[i] = 0;
                end
                if (div_load[i]) begin
                    m_p[i] = ld;
                    if (at_end) begin
                        m_d[i] = ld; m_pf[i] = 0;
                    end else begin
                        m_pf[i] = 1;
                    end
                end else if (at_end && m_pf[i]) begin
                    m_d[i] = m_p[i]; m_pf[i] = 0;
                end
            end
        end
        if (rst) live = 1'b1;
    end

    always @(negedge clk_in) begin
        if (live) begin
            logic [N-1:0] ec;
            logic [N-1:0] et;
            logic [N-1:0] ep;
            for (int i = 0; i < N; i++) begin
                ec[i] = m_clk[i]; et[i] = m_tick[i]; ep[i] = m_pf[i];
            end
            checks++;
            if ({clk_out, tick, pend} !== {ec, et, ep}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t clk_out=%b exp=%b tick=%b exp=%b pend=%b exp=%b",
                         $time, clk_out, ec, tick, et, pend, ep);
            end
`ifdef CLKDIV_READBACK_EN
            for (int i = 0; i < N; i++) begin
                checks++;
                if (int'(div_cur[i*W +: W]) != m_d[i]) begin
                    errors++;
                    $display("FAIL div_cur ch%0d got=%0d exp=%0d", i, div_cur[i*W +: W], m_d[i]);
                end
            end
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
        end
    endtask

    task automatic set_div(input int ch, input int v);
        div_in[ch*W +: W] = W'(v);
    endtask

    task automatic step();
        @(negedge clk_in);
    endtask

    initial begin
        repeat (2) step();
        chk("rst_clk", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_pend", 32'(pend), 0);
        rst = 1'b0;
        en  = '1;

        // Default divide-by-28 waveform
        for (int n = 1; n <= 28; n++) begin
            step();
            chk("def_clk", 32'(clk_out), (n >= 14 && n <= 27) ? 32'hF : 32'h0);
            chk("def_tick", 32'(tick), (n == 28) ? 32'hF : 32'h0);
        end

        // Reload ch0 to 5 and ch1 to 0-then-1 (clamped to 2) mid-period
        repeat (10) step();
        set_div(0, 5);
        div_load = 4'b0001;
        step();
        chk("pend0_set", 32'(pend[0]), 1);
        set_div(1, 0);
        div_load = 4'b0010;
        step();
        set_div(1, 1);
        step();
        div_load = '0;
        chk("pend_waiting", 32'(pend), 32'h3);
        repeat (15) step();
        chk("wrap_tick", 32'(tick), 32'hF);
        chk("wrap_pend", 32'(pend), 0);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("d5_clk", 32'(clk_out[0]), ((k % 5) >= 3) ? 1 : 0);
            chk("d5_tick", 32'(tick[0]), ((k % 5) == 0) ? 1 : 0);
            chk("d2_clk", 32'(clk_out[1]), ((k % 2) == 1) ? 1 : 0);
            chk("d2_tick", 32'(tick[1]), ((k % 2) == 0) ? 1 : 0);
        end

        // Pause ch2 in its high phase
        repeat (6) step();
        chk("ch2_high", 32'(clk_out[2]), 1);
        en[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("ch2_hold_clk", 32'(clk_out[2]), 1);
            chk("ch2_hold_tick", 32'(tick[2]), 0);
        end
        en = '1;
        repeat (20) step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                en[i]       = ($urandom_range(7) != 0);
                div_load[i] = ($urandom_range(15) == 0);
                set_div(i, ($urandom_range(9) == 0) ? $urandom_range(40) : $urandom_range(12));
            end
            align = ($urandom_range(199) == 0);
            rst   = ($urandom_range(499) == 0);
            step();
        end
        rst = 1'b0; align = 1'b0; div_load = '0; en = '1;

        // Load 6, 9, 28, 4 with an align, run freely, then realign
        set_div(0, 6); set_div(1, 9); set_div(2, 28); set_div(3, 4);
        div_load = '1;
        align    = 1'b1;
        step();
        div_load = '0;
        align    = 1'b0;
        chk("al_load_pend", 32'(pend), 0);
        chk("al_load_clk", 32'(clk_out), 0);
        repeat (37) step();
        align = 1'b1;
        step();
        align = 1'b0;
        chk("align_clk", 32'(clk_out), 0);
        chk("align_tick", 32'(tick), 0);
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("al_ch0", 32'(clk_out[0]), ((k % 6) >= 3) ? 1 : 0);
            chk("al_ch2", 32'(clk_out[2]), (k >= 14) ? 1 : 0);
        end

        // Reset discards a pending divisor on ch3
        set_div(3, 7);
        div_load = 4'b1000;
        step();
        div_load = '0;
        chk("ch3_pend", 32'(pend[3]), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_pend", 32'(pend), 0);
        chk("rst2_clk", 32'(clk_out), 0);
        for (int k = 1; k <= 28; k++) begin
            step();
            chk("rst2_ch3", 32'(clk_out[3]), (k >= 14 && k <= 27) ? 1 : 0);
        end
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clock_div_multi.md
Name: clock_div_multi

Overview:
- Parametrised multi-channel clock divider that generalises the fixed divide-by-28 generator used on the board.
- NUM_CH independent channels, each dividing clk_in by a runtime-programmable integer D ≥ 2.
- Each channel provides a registered divided clock and a one-cycle tick strobe.
- Used to derive display refresh, debounce, and blink rates from one master clock. Divisor changes are glitch-free and all channels can be phase-aligned.

Parameters:
- NUM_CH, 4, number of divider channels.
- CNT_W, 16, width of the divisor and the counter in each channel.
- DEFAULT_DIV, 28, divisor loaded into every channel at reset. Must be ≥ 2 and < 2^CNT_W.

Ports:
- clk_in  input  1  master clock; the only clock in the block.
- rst  input  1  reset, synchronous and active-high, sampled on posedge clk_in.
- en  input  NUM_CH  per-channel count enable.
- div_in  input  NUM_CH*CNT_W  divisor values; channel i uses bits [i*CNT_W +: CNT_W].
- div_load  input  NUM_CH  per-channel divisor load strobe.
- align  input  1  restarts all channels in phase.
- clk_out  output  NUM_CH  divided clock per channel, registered.
- tick  output  NUM_CH  one-cycle strobe per channel, once per period.
- pend  output  NUM_CH  high while a loaded divisor is waiting to be applied.

Behaviour:
- Per-channel state:
  - D: active divisor.
  - P: pending divisor.
  - pf: pending flag (drives pend).
  - c: counter, range 0..D-1.
  - Phase lengths: H = D>>1 (high phase), L = D-H (low phase). For odd D the extra cycle goes to the low phase.
- Reset (rst=1 at an edge): D=DEFAULT_DIV, P=DEFAULT_DIV, pf=0, c=0, clk_out=0, tick=0, pend=0. Reset has priority over every other input.
- Enabled cycle (en[i]=1):
  - c_next = (c==D-1) ? 0 : c+1.
  - c <= c_next.
  - clk_out[i] <= (c_next ≥ L).
  - tick[i] <= (c_next==0).
- Resulting output timing:
  - clk_out is low for L enabled cycles, then high for H.
  - tick coincides with the first low cycle of each period.
  - Both are registered and glitch-free.
- Disabled cycle (en[i]=0): c and clk_out hold, tick <= 0. Pending divisor is not applied.
- Divisor load (div_load[i]=1):
  - P <= div_in slice, clamped: values 0 and 1 become 2.
  - pf <= 1.
  - A later load before application overwrites P (last wins).
- Application: on an enabled wrap edge (c==D-1, en=1), if pf=1 then D <= P and pf <= 0. The new divisor governs the period starting at c=0, so no runt pulse is produced.
- Load and wrap in the same cycle: the new div_in value is applied directly at that wrap; pf stays 0.
- align=1 (lower priority than rst only), for every channel regardless of en:
  - c <= 0, clk_out <= 0, tick <= 0.
  - If pf=1 (or div_load in the same cycle), the divisor is applied immediately and pf <= 0.
- Width rules:
  - Counter compare is unsigned CNT_W-bit.
  - c never exceeds D-1, including after a D decrease, because a decrease only takes effect at a wrap or an align.
- Latency:
  - clk_out/tick change one edge after the counter state that produces them.
  - First rising edge of clk_out after reset or align: L enabled edges later.

Optional Feature:
- Macro: CLKDIV_READBACK_EN.
- Defined: adds output div_cur (NUM_CH*CNT_W), a registered copy of each channel's active D. Reset value is DEFAULT_DIV per slice; it updates on the same edge D changes.
- Undefined: the port and its registers are absent. All other behaviour is identical.

Test Plan:
- Reset, then en=all-ones, default D=28 → each clk_out low for edges 1–13, high for edges 14–27, low again at edge 28. Period is 28, tick high exactly at edges 28, 56, …
- Load D=5 on ch0 mid-period → pend[0]=1 until the current 28-cycle period wraps. After that: clk_out low 3, high 2, tick every 5 cycles, no short pulse.
- Load 0 then 1 on ch1 → clamped to 2. After the wrap, clk_out[1] toggles every cycle and tick is high every second cycle.
- en[2] dropped for 10 cycles mid-high-phase → clk_out[2] stays 1, no tick. Resuming continues the count with no lost or extra cycle.
- Channels at D=6, 9, 28, 4 running freely, then align pulse → all clk_out=0 and all c=0 on the next edge. ch0 rises 3 edges later and ch2 14 edges later.
- rst asserted mid-period with pf=1 on ch3 → D=28, pend=0, all outputs 0 on the next edge. Pending value discarded.
